// File: rtl/axi4_arb_pkg.sv
// Shared definitions for the 2:1 AXI4 arbiter: FSM state encodings,
// master-index type and a one-hot to index helper.
package axi4_arb_pkg;

  // Two masters need a single index bit.
  localparam int IDX_W = 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  // Index of a one-hot two-bit grant; an empty grant maps to master 0.
  function automatic idx_t onehot_to_idx(input logic [1:0] oh);
    return (oh == 2'b10) ? idx_t'(1) : idx_t'(0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter with a registered one-hot grant.
// The grant is captured while unlocked, held while locked, and released
// on done, at which point the priority moves to the master not just served.
module rr_arb2
  import axi4_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       lock,   // owning FSM is mid-transaction
  input  logic       done,   // final handshake of the granted transaction
  output logic [1:0] grant
);

  idx_t       ptr;   // master that wins a tie
  logic [1:0] pick;

  // Choose the winner for this cycle's requests.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    pick = 2'b00;
    if (req[0] && req[1]) begin
      pick = (ptr == idx_t'(1)) ? 2'b10 : 2'b01;
    end else begin
      pick = req;
    end
  end

  // Grant and priority pointer registers.
  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant <= 2'b00;
      ptr   <= idx_t'(0);
    end else if (done) begin
      grant <= 2'b00;
      ptr   <= ~onehot_to_idx(grant);
    end else if (!lock) begin
      grant <= pick;
    end
  end

endmodule

// File: rtl/axi4_arbiter_2x1.sv
// 2:1 AXI4 arbiter in front of a single AXI4 RAM slave port.
// Read and write paths each own an FSM and a round-robin arbiter and run
// independently. Once granted, every channel is a pure combinational mux:
// no buffering and no added latency per beat. Burst length is tracked only
// through rlast / wlast from the data stream itself.
module axi4_arbiter_2x1
  import axi4_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 64,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  // master 0
  input  logic                  io_in0_awvalid,
  input  logic [ADDR_WIDTH-1:0] io_in0_awaddr,
  output logic                  io_in0_awready,
  input  logic                  io_in0_wvalid,
  input  logic [DATA_WIDTH-1:0] io_in0_wdata,
  input  logic [STRB_WIDTH-1:0] io_in0_wstrb,
  input  logic                  io_in0_wlast,
  output logic                  io_in0_wready,
  input  logic                  io_in0_bready,
  output logic                  io_in0_bvalid,
  input  logic                  io_in0_arvalid,
  input  logic [ADDR_WIDTH-1:0] io_in0_araddr,
  input  logic [7:0]            io_in0_arlen,
  input  logic [2:0]            io_in0_arsize,
  input  logic [1:0]            io_in0_arburst,
  output logic                  io_in0_arready,
  input  logic                  io_in0_rready,
  output logic                  io_in0_rvalid,
  output logic [DATA_WIDTH-1:0] io_in0_rdata,
  output logic                  io_in0_rlast,
  // master 1
  input  logic                  io_in1_awvalid,
  input  logic [ADDR_WIDTH-1:0] io_in1_awaddr,
  output logic                  io_in1_awready,
  input  logic                  io_in1_wvalid,
  input  logic [DATA_WIDTH-1:0] io_in1_wdata,
  input  logic [STRB_WIDTH-1:0] io_in1_wstrb,
  input  logic                  io_in1_wlast,
  output logic                  io_in1_wready,
  input  logic                  io_in1_bready,
  output logic                  io_in1_bvalid,
  input  logic                  io_in1_arvalid,
  input  logic [ADDR_WIDTH-1:0] io_in1_araddr,
  input  logic [7:0]            io_in1_arlen,
  input  logic [2:0]            io_in1_arsize,
  input  logic [1:0]            io_in1_arburst,
  output logic                  io_in1_arready,
  input  logic                  io_in1_rready,
  output logic                  io_in1_rvalid,
  output logic [DATA_WIDTH-1:0] io_in1_rdata,
  output logic                  io_in1_rlast,
  // slave
  output logic                  io_out_awvalid,
  output logic [ADDR_WIDTH-1:0] io_out_awaddr,
  input  logic                  io_out_awready,
  output logic                  io_out_wvalid,
  output logic [DATA_WIDTH-1:0] io_out_wdata,
  output logic [STRB_WIDTH-1:0] io_out_wstrb,
  output logic                  io_out_wlast,
  input  logic                  io_out_wready,
  output logic                  io_out_bready,
  input  logic                  io_out_bvalid,
  output logic                  io_out_arvalid,
  output logic [ADDR_WIDTH-1:0] io_out_araddr,
  output logic [7:0]            io_out_arlen,
  output logic [2:0]            io_out_arsize,
  output logic [1:0]            io_out_arburst,
  input  logic                  io_out_arready,
  output logic                  io_out_rready,
  input  logic                  io_out_rvalid,
  input  logic [DATA_WIDTH-1:0] io_out_rdata,
  input  logic                  io_out_rlast
);

  rd_state_e  rd_state, rd_next;
  wr_state_e  wr_state, wr_next;
  logic [1:0] rd_grant, wr_grant;
  logic       rd_done, wr_done;

  // The final R beat and the B handshake close their transactions.
  assign rd_done = (rd_state == R_DATA) && io_out_rvalid && io_out_rready && io_out_rlast;
  assign wr_done = (wr_state == W_RESP) && io_out_bvalid && io_out_bready;

  rr_arb2 u_rd_arb (
    .clock (clock),
    .reset (reset),
    .req   ({io_in1_arvalid, io_in0_arvalid}),
    .lock  (rd_state != R_IDLE),
    .done  (rd_done),
    .grant (rd_grant)
  );

  rr_arb2 u_wr_arb (
    .clock (clock),
    .reset (reset),
    .req   ({io_in1_awvalid, io_in0_awvalid}),
    .lock  (wr_state != W_IDLE),
    .done  (wr_done),
    .grant (wr_grant)
  );

  // Read and write FSM state registers; reset abandons any grant at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // Read FSM next state: arbitrate, forward AR, stream R until rlast.
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (io_in0_arvalid || io_in1_arvalid) rd_next = R_ADDR;
      R_ADDR:  if (io_out_arvalid && io_out_arready) rd_next = R_DATA;
      R_DATA:  if (rd_done) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Write FSM next state: arbitrate, forward AW, W until wlast, then B.
  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: if (io_in0_awvalid || io_in1_awvalid) wr_next = W_ADDR;
      W_ADDR: if (io_out_awvalid && io_out_awready) wr_next = W_DATA;
      W_DATA: if (io_out_wvalid && io_out_wready && io_out_wlast) wr_next = W_RESP;
      W_RESP: if (wr_done) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Read datapath: payload muxes run freely, valids/readies are gated by state and grant.
  always_comb begin
    io_out_araddr  = rd_grant[1] ? io_in1_araddr  : io_in0_araddr;
    io_out_arlen   = rd_grant[1] ? io_in1_arlen   : io_in0_arlen;
    io_out_arsize  = rd_grant[1] ? io_in1_arsize  : io_in0_arsize;
    io_out_arburst = rd_grant[1] ? io_in1_arburst : io_in0_arburst;
    io_in0_rdata   = io_out_rdata;
    io_in1_rdata   = io_out_rdata;
    io_in0_rlast   = io_out_rlast;
    io_in1_rlast   = io_out_rlast;
    io_out_arvalid = 1'b0;
    io_out_rready  = 1'b0;
    io_in0_arready = 1'b0;
    io_in1_arready = 1'b0;
    io_in0_rvalid  = 1'b0;
    io_in1_rvalid  = 1'b0;
    unique case (rd_state)
      R_ADDR: begin
        io_out_arvalid = rd_grant[1] ? io_in1_arvalid : io_in0_arvalid;
        io_in0_arready = rd_grant[0] && io_out_arready;
        io_in1_arready = rd_grant[1] && io_out_arready;
      end
      R_DATA: begin
        io_out_rready = rd_grant[1] ? io_in1_rready : io_in0_rready;
        io_in0_rvalid = rd_grant[0] && io_out_rvalid;
        io_in1_rvalid = rd_grant[1] && io_out_rvalid;
      end
      default: ;
    endcase
  end

  // Write datapath: same scheme across the AW, W and B channels.
  always_comb begin
    io_out_awaddr  = wr_grant[1] ? io_in1_awaddr : io_in0_awaddr;
    io_out_wdata   = wr_grant[1] ? io_in1_wdata  : io_in0_wdata;
    io_out_wstrb   = wr_grant[1] ? io_in1_wstrb  : io_in0_wstrb;
    io_out_wlast   = wr_grant[1] ? io_in1_wlast  : io_in0_wlast;
    io_out_awvalid = 1'b0;
    io_out_wvalid  = 1'b0;
    io_out_bready  = 1'b0;
    io_in0_awready = 1'b0;
    io_in1_awready = 1'b0;
    io_in0_wready  = 1'b0;
    io_in1_wready  = 1'b0;
    io_in0_bvalid  = 1'b0;
    io_in1_bvalid  = 1'b0;
    unique case (wr_state)
      W_ADDR: begin
        io_out_awvalid = wr_grant[1] ? io_in1_awvalid : io_in0_awvalid;
        io_in0_awready = wr_grant[0] && io_out_awready;
        io_in1_awready = wr_grant[1] && io_out_awready;
      end
      W_DATA: begin
        io_out_wvalid = wr_grant[1] ? io_in1_wvalid : io_in0_wvalid;
        io_in0_wready = wr_grant[0] && io_out_wready;
        io_in1_wready = wr_grant[1] && io_out_wready;
      end
      W_RESP: begin
        io_out_bready = wr_grant[1] ? io_in1_bready : io_in0_bready;
        io_in0_bvalid = wr_grant[0] && io_out_bvalid;
        io_in1_bvalid = wr_grant[1] && io_out_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_arbiter_2x1.sv
// Directed bench for axi4_arbiter_2x1: two driven masters, a small
// behavioural AXI4 RAM slave, and hand-computed expectations.
module tb_axi4_arbiter_2x1;

  localparam int WAIT_MAX = 100;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // master-side drive (index = master)
  logic [1:0]       m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
  logic [1:0][31:0] m_awaddr, m_araddr;
  logic [1:0][63:0] m_wdata;
  logic [1:0][7:0]  m_wstrb, m_arlen;
  logic [1:0][2:0]  m_arsize;
  logic [1:0][1:0]  m_arburst;
  // master-side observe
  logic [1:0]       in_awready, in_wready, in_bvalid, in_arready, in_rvalid, in_rlast;
  logic [1:0][63:0] in_rdata;
  // slave port
  logic        o_awvalid, o_wvalid, o_wlast, o_bready, o_arvalid, o_rready;
  logic [31:0] o_awaddr, o_araddr;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb, o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [63:0] s_rdata;

  axi4_arbiter_2x1 dut (
    .clock(clock), .reset(reset),
    .io_in0_awvalid(m_awvalid[0]), .io_in0_awaddr(m_awaddr[0]), .io_in0_awready(in_awready[0]),
    .io_in0_wvalid(m_wvalid[0]), .io_in0_wdata(m_wdata[0]), .io_in0_wstrb(m_wstrb[0]),
    .io_in0_wlast(m_wlast[0]), .io_in0_wready(in_wready[0]),
    .io_in0_bready(m_bready[0]), .io_in0_bvalid(in_bvalid[0]),
    .io_in0_arvalid(m_arvalid[0]), .io_in0_araddr(m_araddr[0]), .io_in0_arlen(m_arlen[0]),
    .io_in0_arsize(m_arsize[0]), .io_in0_arburst(m_arburst[0]), .io_in0_arready(in_arready[0]),
    .io_in0_rready(m_rready[0]), .io_in0_rvalid(in_rvalid[0]), .io_in0_rdata(in_rdata[0]),
    .io_in0_rlast(in_rlast[0]),
    .io_in1_awvalid(m_awvalid[1]), .io_in1_awaddr(m_awaddr[1]), .io_in1_awready(in_awready[1]),
    .io_in1_wvalid(m_wvalid[1]), .io_in1_wdata(m_wdata[1]), .io_in1_wstrb(m_wstrb[1]),
    .io_in1_wlast(m_wlast[1]), .io_in1_wready(in_wready[1]),
    .io_in1_bready(m_bready[1]), .io_in1_bvalid(in_bvalid[1]),
    .io_in1_arvalid(m_arvalid[1]), .io_in1_araddr(m_araddr[1]), .io_in1_arlen(m_arlen[1]),
    .io_in1_arsize(m_arsize[1]), .io_in1_arburst(m_arburst[1]), .io_in1_arready(in_arready[1]),
    .io_in1_rready(m_rready[1]), .io_in1_rvalid(in_rvalid[1]), .io_in1_rdata(in_rdata[1]),
    .io_in1_rlast(in_rlast[1]),
    .io_out_awvalid(o_awvalid), .io_out_awaddr(o_awaddr), .io_out_awready(s_awready),
    .io_out_wvalid(o_wvalid), .io_out_wdata(o_wdata), .io_out_wstrb(o_wstrb),
    .io_out_wlast(o_wlast), .io_out_wready(s_wready),
    .io_out_bready(o_bready), .io_out_bvalid(s_bvalid),
    .io_out_arvalid(o_arvalid), .io_out_araddr(o_araddr), .io_out_arlen(o_arlen),
    .io_out_arsize(o_arsize), .io_out_arburst(o_arburst), .io_out_arready(s_arready),
    .io_out_rready(o_rready), .io_out_rvalid(s_rvalid), .io_out_rdata(s_rdata),
    .io_out_rlast(s_rlast)
  );

  // All ready/valid outputs of the DUT in one vector.
  logic [14:0] hs_flags;
  assign hs_flags = {in_awready, in_wready, in_bvalid, in_arready, in_rvalid,
                     o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready};

  function automatic logic [63:0] init_word(input int i);
    logic [31:0] hi, lo;
    hi = 32'hD0D0_0000 + 32'(i);
    lo = 32'hC0C0_0000 + 32'(i);
    return {hi, lo};
  endfunction

  function automatic logic [5:0] widx(input logic [31:0] a);
    return 6'((a >> 3) & 32'h3F);
  endfunction

  // ---------------- behavioural AXI4 RAM slave ----------------
  logic [63:0] mem [64];
  logic        rbusy;
  logic [31:0] raddr, rstep, waddr;
  logic [7:0]  rleft;
  logic [1:0]  wst;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      s_arready <= 1'b0; s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rdata <= '0;
      rbusy <= 1'b0; raddr <= '0; rstep <= '0; rleft <= '0;
      s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; wst <= 2'd0; waddr <= '0;
    end else begin
      if (!rbusy) begin
        s_arready <= 1'b1;
        if (s_arready && o_arvalid) begin
          s_arready <= 1'b0;
          rbusy     <= 1'b1;
          s_rvalid  <= 1'b1;
          s_rdata   <= mem[widx(o_araddr)];
          s_rlast   <= (o_arlen == 8'd0);
          rleft     <= o_arlen;
          raddr     <= o_araddr;
          rstep     <= (o_arburst == 2'b01) ? (32'd1 << o_arsize) : 32'd0;
        end
      end else if (s_rvalid && o_rready) begin
        if (s_rlast) begin
          s_rvalid <= 1'b0; s_rlast <= 1'b0; rbusy <= 1'b0;
        end else begin
          s_rdata <= mem[widx(raddr + rstep)];
          raddr   <= raddr + rstep;
          rleft   <= rleft - 8'd1;
          s_rlast <= (rleft == 8'd1);
        end
      end
      case (wst)
        2'd0: begin
          s_awready <= 1'b1;
          if (s_awready && o_awvalid) begin
            s_awready <= 1'b0; s_wready <= 1'b1; waddr <= o_awaddr; wst <= 2'd1;
          end
        end
        2'd1: if (o_wvalid && s_wready) begin
          for (int b = 0; b < 8; b++)
            if (o_wstrb[b]) mem[widx(waddr)][b*8 +: 8] <= o_wdata[b*8 +: 8];
          waddr <= waddr + 32'd8;
          if (o_wlast) begin
            s_wready <= 1'b0; s_bvalid <= 1'b1; wst <= 2'd2;
          end
        end
        default: if (s_bvalid && o_bready) begin
          s_bvalid <= 1'b0; wst <= 2'd0;
        end
      endcase
    end
  end

  // ---------------- monitors ----------------
  int rv1_cycles = 0;
  int rv_both    = 0;
  int ar_both    = 0;
  always @(negedge clock) begin
    if (in_rvalid[1]) rv1_cycles <= rv1_cycles + 1;
    if (&in_rvalid)   rv_both    <= rv_both + 1;
    if (&in_arready)  ar_both    <= ar_both + 1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [63:0] rbuf [2][16];

  // Issue one read burst from master m and capture its beats.
  task automatic rd(input int m, input logic [31:0] addr, input logic [7:0] len,
                    output int nbeat, output time ar_t, output time last_t);
    bit got;
    nbeat = 0; ar_t = 0; last_t = 0; got = 1'b0;
    m_araddr[m] = addr; m_arlen[m] = len; m_arsize[m] = 3'd3; m_arburst[m] = 2'b01;
    m_arvalid[m] = 1'b1;
    for (int k = 0; k < WAIT_MAX && !got; k++) begin
      @(negedge clock);
      if (in_arready[m]) begin got = 1'b1; ar_t = $time; end
    end
    @(posedge clock); #1;
    m_arvalid[m] = 1'b0;
    check("rd_ar_handshake", 64'(got), 64'd1);
    m_rready[m] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < WAIT_MAX && !got; k++) begin
      @(negedge clock);
      if (in_rvalid[m]) begin
        rbuf[m][nbeat % 16] = in_rdata[m];
        nbeat++;
        if (in_rlast[m]) begin got = 1'b1; last_t = $time; end
      end
    end
    @(posedge clock); #1;
    m_rready[m] = 1'b0;
    check("rd_last_seen", 64'(got), 64'd1);
  endtask

  // Single-beat write from master m; bready held low bdelay cycles after bvalid.
  task automatic wr(input int m, input logic [31:0] addr, input logic [63:0] data,
                    input logic [7:0] strb, input int bdelay,
                    output time aw_t, output time b_t, output int held);
    bit got;
    aw_t = 0; b_t = 0; held = 0; got = 1'b0;
    m_awaddr[m] = addr; m_awvalid[m] = 1'b1;
    for (int k = 0; k < WAIT_MAX && !got; k++) begin
      @(negedge clock);
      if (in_awready[m]) begin got = 1'b1; aw_t = $time; end
    end
    @(posedge clock); #1;
    m_awvalid[m] = 1'b0;
    check("wr_aw_handshake", 64'(got), 64'd1);
    m_wdata[m] = data; m_wstrb[m] = strb; m_wlast[m] = 1'b1; m_wvalid[m] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < WAIT_MAX && !got; k++) begin
      @(negedge clock);
      if (in_wready[m]) got = 1'b1;
    end
    @(posedge clock); #1;
    m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    check("wr_w_handshake", 64'(got), 64'd1);
    got = 1'b0;
    for (int k = 0; k < WAIT_MAX && !got; k++) begin
      @(negedge clock);
      if (in_bvalid[m]) got = 1'b1;
    end
    check("wr_bvalid_seen", 64'(got), 64'd1);
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clock);
      if (in_bvalid[m]) held++;
    end
    m_bready[m] = 1'b1;
    b_t = $time;
    @(posedge clock); #1;
    m_bready[m] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    time t_a0, t_a1, t_l0, t_l1, ta0, ta1, tb0, tb1;
    int  n0, n1, held0, held1, snap, nb;
    bit  got;
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0; m_arlen = '0;
    m_arsize = '0; m_arburst = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    check("reset_flags", 64'(hs_flags), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Simultaneous requests after reset: master 0 first, then master 1.
    fork
      rd(0, 32'h8000_0000, 8'd0, n0, t_a0, t_l0);
      rd(1, 32'h8000_0008, 8'd0, n1, t_a1, t_l1);
    join
    check("rr1_m0_before_m1", 64'(t_a0 < t_a1), 64'd1);
    check("rr1_m1_after_m0_done", 64'(t_a1 > t_l0), 64'd1);
    check("rr1_m0_data", rbuf[0][0], 64'hD0D00000_C0C00000);
    check("rr1_m1_data", rbuf[1][0], 64'hD0D00001_C0C00001);
    // Third simultaneous request: master 1 was served last, so master 0 wins.
    fork
      rd(0, 32'h8000_0000, 8'd0, n0, t_a0, t_l0);
      rd(1, 32'h8000_0008, 8'd0, n1, t_a1, t_l1);
    join
    check("rr2_m0_before_m1", 64'(t_a0 < t_a1), 64'd1);

    // Master 0 four-beat INCR burst; master 1 never sees rvalid.
    snap = rv1_cycles;
    rd(0, 32'h8000_0000, 8'd3, n0, t_a0, t_l0);
    check("b4_beat_count", 64'(n0), 64'd4);
    for (int k = 0; k < 4; k++) check("b4_beat_data", rbuf[0][k], init_word(k));
    check("b4_m1_rvalid_quiet", 64'(rv1_cycles - snap), 64'd0);

    // Master 1 eight-beat burst; master 0 requests mid-burst and must wait.
    fork
      rd(1, 32'h8000_0040, 8'd7, n1, t_a1, t_l1);
      begin
        repeat (4) @(posedge clock);
        #1;
        rd(0, 32'h8000_0100, 8'd0, n0, t_a0, t_l0);
      end
    join
    check("lock_m1_beats", 64'(n1), 64'd8);
    check("lock_m1_last_data", rbuf[1][7], 64'hD0D0000F_C0C0000F);
    check("lock_m0_after_m1_last", 64'(t_a0 > t_l1), 64'd1);
    check("lock_m0_data", rbuf[0][0], 64'hD0D00020_C0C00020);

    // Concurrent write (m0) and read (m1), then readback of the partial write.
    fork
      wr(0, 32'h8000_0010, 64'h1122334455667788, 8'h0F, 0, ta0, tb0, held0);
      rd(1, 32'h8000_0020, 8'd0, n1, t_a1, t_l1);
    join
    check("conc_rd_during_wr", 64'(t_a1 < tb0), 64'd1);
    check("conc_wr_during_rd", 64'(ta0 < t_l1), 64'd1);
    check("conc_rd_data", rbuf[1][0], 64'hD0D00004_C0C00004);
    rd(1, 32'h8000_0010, 8'd0, n1, t_a1, t_l1);
    check("conc_readback", rbuf[1][0], 64'hD0D00002_55667788);

    // B stalled for 5 cycles; competing AW from master 1 waits for it.
    fork
      wr(0, 32'h8000_0018, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 5, ta0, tb0, held0);
      begin
        repeat (3) @(posedge clock);
        #1;
        wr(1, 32'h8000_0030, 64'h5555_6666_7777_8888, 8'hFF, 0, ta1, tb1, held1);
      end
    join
    check("bstall_bvalid_held", 64'(held0), 64'd5);
    check("bstall_aw_after_b", 64'(ta1 > tb0), 64'd1);
    rd(0, 32'h8000_0030, 8'd0, n0, t_a0, t_l0);
    check("bstall_m1_readback", rbuf[0][0], 64'h5555_6666_7777_8888);

    // Reset during beat 2 of a 4-beat read.
    m_araddr[0] = 32'h8000_0000; m_arlen[0] = 8'd3; m_arsize[0] = 3'd3;
    m_arburst[0] = 2'b01; m_arvalid[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < WAIT_MAX && !got; k++) begin
      @(negedge clock);
      if (in_arready[0]) got = 1'b1;
    end
    @(posedge clock); #1;
    m_arvalid[0] = 1'b0; m_rready[0] = 1'b1;
    nb = 0;
    for (int k = 0; k < WAIT_MAX && nb < 2; k++) begin
      @(negedge clock);
      if (in_rvalid[0]) nb++;
    end
    check("rst_mid_beats_before", 64'(nb), 64'd2);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_flags", 64'(hs_flags), 64'd0);
    m_rready[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    rd(0, 32'h8000_0000, 8'd3, n0, t_a0, t_l0);
    check("rst_fresh_beats", 64'(n0), 64'd4);
    check("rst_fresh_beat3", rbuf[0][3], 64'hD0D00003_C0C00003);

    check("rvalid_exclusive", 64'(rv_both), 64'd0);
    check("arready_exclusive", 64'(ar_both), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_arbiter_2x1.md
AXI4_ARBITER_2X1 -- requirements
Module: axi4_arbiter_2x1

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of the address bus on all ports.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the data width; STRB_WIDTH is DATA_WIDTH/8.
REQ-003 clock  in  1  single clock for the whole block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_inN_aw{valid,addr} (N=0,1)  in  1/ADDR_WIDTH  write address from master N; io_inN_awready  out  1.
REQ-006 io_inN_w{valid,data,strb,last}  in  1/DATA_WIDTH/STRB_WIDTH/1  write data from master N; io_inN_wready  out  1.
REQ-007 io_inN_bready  in  1; io_inN_bvalid  out  1  write response to master N.
REQ-008 io_inN_ar{valid,addr,len,size,burst}  in  1/ADDR_WIDTH/8/3/2  read address from master N; io_inN_arready  out  1.
REQ-009 io_inN_rready  in  1; io_inN_r{valid,data,last}  out  1/DATA_WIDTH/1  read data to master N.
REQ-010 io_out_* SHALL be the same signal set with directions reversed, connecting to one AXI4RAM slave port.

Function
REQ-011 The read and write paths SHALL be arbitrated independently and SHALL run concurrently.
REQ-012 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA; write FSM states SHALL be W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-013 In R_IDLE with any io_inN_arvalid, the block SHALL register a grant and enter R_ADDR on the next edge; arbitration latency is 1 cycle.
REQ-014 Grant selection SHALL be round-robin: if both request, the master not served most recently wins; if one requests, it wins.
REQ-015 In R_ADDR, io_out_ar* SHALL mirror the granted master's ar* and io_out_arready SHALL route to it; on the handshake, the FSM SHALL enter R_DATA.
REQ-016 In R_DATA, io_out_r* SHALL route to the granted master and its rready SHALL drive io_out_rready; the beat with rvalid&rready&rlast SHALL return the FSM to R_IDLE and toggle the read priority pointer.
REQ-017 Write arbitration SHALL mirror REQ-013/014 on awvalid; W_ADDR forwards aw* until handshake, W_DATA forwards w* until the wlast beat handshakes, W_RESP forwards b* until bvalid&bready, then W_IDLE.
REQ-018 Non-granted masters SHALL see awready, wready, bvalid, arready and rvalid held at 0; io_out valids SHALL be 0 in every state not forwarding that channel.
REQ-019 The grant SHALL stay locked from arbitration until the final response handshake; new requests SHALL not pre-empt a burst.
REQ-020 A request withdrawn before handshake is illegal AXI; behaviour is unspecified, but the FSM SHALL not deadlock once the master reasserts valid.
REQ-021 The datapath SHALL be purely combinational muxing once granted; there SHALL be no data buffering and no extra latency per beat.
REQ-022 arlen 0..255 SHALL be supported; the beat count comes only from io_out_rlast, with no internal counter.

Reset
REQ-023 On reset, both FSMs SHALL go to IDLE, both priority pointers SHALL select master 0, and all ready/valid outputs SHALL be 0 in the cycle after reset is sampled.
REQ-024 Reset mid-transaction SHALL abandon the grant immediately; the slave shares the same reset and no completion is owed.

Structure
REQ-025 FSM state encodings and the master-index width SHALL live in a shared package, axi4_arb_pkg.
REQ-026 A sub-module rr_arb2 (two requests, lock input, registered one-hot grant and pointer) SHALL be instantiated once per path.

Verification
REQ-027 Master 0 reads addr 0x80000000, len 3, INCR -> 4 beats to master 0 only, rlast on beat 4, master 1 rvalid stays 0.
REQ-028 Both masters assert arvalid in the same cycle after reset -> master 0 is served first, then master 1; after a third simultaneous request, master 0 is served.
REQ-029 Master 1 starts a len-7 read; master 0 arvalid rises mid-burst -> master 0 arready stays 0 until master 1's last beat, then it is granted.
REQ-030 Master 0 writes 0x1122334455667788 with wstrb 0x0F to 0x80000010 while master 1 reads 0x80000020 -> both complete concurrently; a readback of 0x80000010 by master 1 returns the lower 4 bytes updated.
REQ-031 A master holds bready=0 for 5 cycles -> bvalid is held, and a competing awvalid is not accepted until the B handshake.
REQ-032 Reset asserted during R_DATA beat 2 of 4 -> all outputs are 0 the next cycle, and a fresh read afterwards completes correctly.
